// File: rtl/ssd_pkg.sv
// ssd_pkg: shared types and constants for the seven-segment driver.
package ssd_pkg;
    typedef enum logic {IDLE, SHIFT} state_t;
    localparam int NUM_W      = 13;
    localparam int BCD_DIGITS = 4;
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_TABLE [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };
    localparam logic [3:0] AN_UNITS     = 4'b1110;
    localparam logic [3:0] AN_TENS      = 4'b1101;
    localparam logic [3:0] AN_HUNDREDS  = 4'b1011;
    localparam logic [3:0] AN_THOUSANDS = 4'b0111;
    localparam logic [3:0] AN_OFF       = 4'b1111;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        return (d > 4'd9) ? SEG_BLANK : SEG_TABLE[d];
    endfunction
endpackage

// File: rtl/ssd_driver_bin2bcd.sv
// bin2bcd_seq: sequential double-dabble converter; publishes digits only after
// the final shift so a partial result is never visible.
module bin2bcd_seq
    import ssd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [NUM_W-1:0] num,
    output logic             busy,
    output logic [BCD_W-1:0] bcd
);
    localparam logic [3:0] LAST = 4'(NUM_W - 1);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [NUM_W-1:0] bin_q, bin_d, last_q, last_d;
    logic [BCD_W-1:0] scr_q, scr_d, bcd_q, bcd_d, adj;

    always_comb begin
        adj = scr_q;
        for (int i = 0; i < BCD_DIGITS; i++)
            adj[4*i +: 4] = (scr_q[4*i +: 4] >= 4'd5) ? scr_q[4*i +: 4] + 4'd3 : scr_q[4*i +: 4];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        last_d  = last_q;
        scr_d   = scr_q;
        bcd_d   = bcd_q;
        if (state_q == IDLE) begin
            if (num != last_q) begin
                bin_d   = num;
                last_d  = num;
                scr_d   = '0;
                cnt_d   = '0;
                state_d = SHIFT;
            end
        end else begin
            {scr_d, bin_d} = {adj, bin_q} << 1;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == LAST) begin
                bcd_d   = scr_d;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            last_q  <= '0;
            scr_q   <= '0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            last_q  <= last_d;
            scr_q   <= scr_d;
            bcd_q   <= bcd_d;
        end
    end

    assign busy = (state_q == SHIFT);
    assign bcd  = bcd_q;
endmodule

// File: rtl/ssd_driver.sv
// ssd_driver: BCD conversion and 4-digit multiplexed common-anode display.
// Define SSD_BLANK_EN to blank leading zeros (units always lit).
module ssd_driver
    import ssd_pkg::*;
#(
    parameter int REFRESH_BITS = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NUM_W-1:0] Num,
    output logic             Busy,
    output logic [3:0]       Anode,
    output logic [6:0]       Segments
);
    logic [REFRESH_BITS-1:0] cnt_q, cnt_d;
    logic [BCD_W-1:0]        bcd;
    logic [1:0]              sel;
    logic [3:0]              digit, anode_d, anode_q;
    logic [6:0]              seg_d, seg_q;
    logic                    blank;

    bin2bcd_seq u_bcd (
        .clk  (clk),
        .rst  (rst),
        .num  (Num),
        .busy (Busy),
        .bcd  (bcd)
    );

    always_comb begin
        cnt_d = cnt_q + REFRESH_BITS'(1);
        sel   = cnt_q[REFRESH_BITS-1 -: 2];
        digit = bcd[4*sel +: 4];
`ifdef SSD_BLANK_EN
        // a slot is a leading zero when it and every digit above it are zero
        blank = (sel != 2'd0) && ((bcd >> {sel, 2'b00}) == '0);
`else
        blank = 1'b0;
`endif
        anode_d = blank ? AN_OFF :
                  (sel == 2'd0) ? AN_UNITS :
                  (sel == 2'd1) ? AN_TENS :
                  (sel == 2'd2) ? AN_HUNDREDS : AN_THOUSANDS;
        seg_d   = blank ? SEG_BLANK : seg_decode(digit);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            anode_q <= AN_OFF;
            seg_q   <= SEG_BLANK;
        end else begin
            cnt_q   <= cnt_d;
            anode_q <= anode_d;
            seg_q   <= seg_d;
        end
    end

    assign Anode    = anode_q;
    assign Segments = seg_q;
endmodule
